spi_frame_assembler: RTL and testbench

Consumes the serial bit stream and the two header-match strobes produced by the 2-channel sequence comparator in the SPI slave driver. It turns each detected frame into a byte stream: length byte, then payload bytes, then an optional checksum byte. Payload bytes go to the register/command layer over a valid/ready handshake, tagged with the frame type. It also reports frame completion and errors.

---
 rtl/spi_frame_assembler.sv | 170 +++++++++++++++++
 tb/tb_spi_frame_assembler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_assembler.sv
// Turns header-delimited serial frames into payload bytes over a valid/ready handshake.
// Optional trailing XOR checksum byte is enabled by defining FRAME_CHECKSUM_EN.
module spi_frame_assembler #(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sequence_in,
    input  logic       hdr_match0,
    input  logic       hdr_match1,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_last,
    output logic       frame_type,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2
`ifdef FRAME_CHECKSUM_EN
        , CSUM  = 2'd3
`endif
    } state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state;
    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic [7:0] byte_in;
    logic       bit_done;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] csum_acc;
`endif

    // Byte formed by the bit being sampled this cycle.
    assign byte_in  = {shreg, sequence_in};
    assign bit_done = (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            frame_type <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_acc   <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
                byte_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hdr_match0 || hdr_match1) begin
                        frame_type <= !hdr_match0;
                        state      <= LEN;
                        frame_busy <= 1'b1;
                        bit_cnt    <= '0;
`ifdef FRAME_CHECKSUM_EN
                        csum_acc   <= '0;
`endif
                    end
                end

                LEN: begin
                    shreg   <= byte_in[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_done) begin
`ifdef FRAME_CHECKSUM_EN
                        csum_acc <= csum_acc ^ byte_in;
`endif
                        if (byte_in > MAX_LEN_B) begin
                            frame_err  <= 1'b1;
                            err_code   <= 2'b01;
                            state      <= IDLE;
                            frame_busy <= 1'b0;
                        end else if (byte_in == 8'd0) begin
`ifdef FRAME_CHECKSUM_EN
                            state      <= CSUM;
`else
                            frame_done <= 1'b1;
                            state      <= IDLE;
                            frame_busy <= 1'b0;
`endif
                        end else begin
                            byte_cnt <= byte_in;
                            state    <= PAYLOAD;
                        end
                    end
                end

                PAYLOAD: begin
                    shreg   <= byte_in[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_done) begin
`ifdef FRAME_CHECKSUM_EN
                        csum_acc <= csum_acc ^ byte_in;
`endif
                        if (byte_valid && !byte_ready) begin
                            // Holding register still occupied: drop the new byte and abort.
                            frame_err  <= 1'b1;
                            err_code   <= 2'b11;
                            byte_valid <= 1'b0;
                            byte_last  <= 1'b0;
                            state      <= IDLE;
                            frame_busy <= 1'b0;
                        end else begin
                            byte_data  <= byte_in;
                            byte_valid <= 1'b1;
                            byte_last  <= (byte_cnt == 8'd1);
                            byte_cnt   <= byte_cnt - 8'd1;
                            if (byte_cnt == 8'd1) begin
`ifdef FRAME_CHECKSUM_EN
                                state      <= CSUM;
`else
                                frame_done <= 1'b1;
                                state      <= IDLE;
                                frame_busy <= 1'b0;
`endif
                            end
                        end
                    end
                end

`ifdef FRAME_CHECKSUM_EN
                CSUM: begin
                    shreg   <= byte_in[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_done) begin
                        if (byte_in == csum_acc) begin
                            frame_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b10;
                        end
                        state      <= IDLE;
                        frame_busy <= 1'b0;
                    end
                end
`endif

                default: begin
                    state      <= IDLE;
                    frame_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_assembler.sv
// Directed bench for spi_frame_assembler; adapts frame layout to FRAME_CHECKSUM_EN.
module tb_spi_frame_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sequence_in = 1'b0;
    logic       hdr_match0 = 1'b0;
    logic       hdr_match1 = 1'b0;
    logic       byte_ready = 1'b1;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       frame_type;
    logic       frame_busy;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

`ifdef FRAME_CHECKSUM_EN
    localparam int CS = 8;
    localparam bit HAS_CS = 1'b1;
`else
    localparam int CS = 0;
    localparam bit HAS_CS = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int h = 0;
    int n_done = 0;
    int n_err = 0;
    int n_valid = 0;
    int done_cyc = -1;
    int err_cyc = -1;
    logic [1:0] seen_code = '0;
    logic [7:0] rx_data[$];
    logic       rx_last[$];

    spi_frame_assembler #(.MAX_LEN(64)) dut (
        .clk(clk), .rst(rst), .sequence_in(sequence_in),
        .hdr_match0(hdr_match0), .hdr_match1(hdr_match1),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .frame_type(frame_type), .frame_busy(frame_busy),
        .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        if (!rst && byte_valid && byte_ready) begin
            rx_data.push_back(byte_data);
            rx_last.push_back(byte_last);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done) begin n_done++; done_cyc = cyc; end
        if (frame_err) begin n_err++; err_cyc = cyc; seen_code = err_code; end
        if (byte_valid) n_valid++;
    endtask

    task automatic clear_log();
        rx_data.delete();
        rx_last.delete();
        n_done = 0; n_err = 0; n_valid = 0; done_cyc = -1; err_cyc = -1;
    endtask

    task automatic header(input bit t);
        h = cyc;
        hdr_match0 = !t;
        hdr_match1 = t;
        tick();
        hdr_match0 = 1'b0;
        hdr_match1 = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic [7:0] sp0, input logic [7:0] sp1);
        for (int i = 7; i >= 0; i--) begin
            sequence_in = b[i];
            hdr_match0 = sp0[i];
            hdr_match1 = sp1[i];
            tick();
        end
        hdr_match0 = 1'b0;
        hdr_match1 = 1'b0;
        sequence_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (byte_data !== 8'h00) begin failures++; $display("FAIL reset_byte_data got=%h exp=00", byte_data); end
        checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%b exp=0", byte_valid); end
        checks++; if (byte_last !== 1'b0) begin failures++; $display("FAIL reset_byte_last got=%b exp=0", byte_last); end
        checks++; if (frame_type !== 1'b0) begin failures++; $display("FAIL reset_frame_type got=%b exp=0", frame_type); end
        checks++; if (frame_busy !== 1'b0) begin failures++; $display("FAIL reset_frame_busy got=%b exp=0", frame_busy); end
        checks++; if ({frame_done, frame_err} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {frame_done, frame_err}); end
        checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL reset_err_code got=%b exp=00", err_code); end
        tick();
    endtask

    task automatic test_good_frame();
        clear_log();
        header(1'b0);
        checks++; if (frame_busy !== 1'b1) begin failures++; $display("FAIL good_busy got=%b exp=1", frame_busy); end
        drive_byte(8'h02, 8'h00, 8'h00);
        drive_byte(8'hA5, 8'h00, 8'h00);
        drive_byte(8'h3C, 8'h00, 8'h00);
        if (HAS_CS) drive_byte(8'h9B, 8'h00, 8'h00);
        tick();
        checks++; if (rx_data.size() !== 2) begin failures++; $display("FAIL good_count got=%0d exp=2", rx_data.size()); end
        if (rx_data.size() == 2) begin
            checks++; if (rx_data[0] !== 8'hA5 || rx_last[0] !== 1'b0) begin failures++; $display("FAIL good_byte0 got=%h/%b exp=a5/0", rx_data[0], rx_last[0]); end
            checks++; if (rx_data[1] !== 8'h3C || rx_last[1] !== 1'b1) begin failures++; $display("FAIL good_byte1 got=%h/%b exp=3c/1", rx_data[1], rx_last[1]); end
        end
        checks++; if (frame_type !== 1'b0) begin failures++; $display("FAIL good_type got=%b exp=0", frame_type); end
        checks++; if (n_done !== 1 || done_cyc !== h + 25 + CS) begin failures++; $display("FAIL good_done got=%0d@%0d exp=1@%0d", n_done, done_cyc - h, 25 + CS); end
        checks++; if (n_err !== 0) begin failures++; $display("FAIL good_no_err got=%0d exp=0", n_err); end
        checks++; if (frame_busy !== 1'b0) begin failures++; $display("FAIL good_idle_busy got=%b exp=0", frame_busy); end
    endtask

    task automatic test_bad_csum();
        clear_log();
        header(1'b0);
        drive_byte(8'h02, 8'h00, 8'h00);
        drive_byte(8'hA5, 8'h00, 8'h00);
        drive_byte(8'h3C, 8'h00, 8'h00);
        drive_byte(8'h9A, 8'h00, 8'h00);
        tick();
        checks++; if (rx_data.size() !== 2) begin failures++; $display("FAIL csum_count got=%0d exp=2", rx_data.size()); end
        checks++; if (n_err !== 1 || err_cyc !== h + 33 || seen_code !== 2'b10) begin failures++; $display("FAIL csum_err got=%0d@%0d code=%b exp=1@33 code=10", n_err, err_cyc - h, seen_code); end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL csum_no_done got=%0d exp=0", n_done); end
    endtask

    task automatic test_len_err();
        clear_log();
        header(1'b1);
        drive_byte(8'h41, 8'h00, 8'h00);
        checks++; if (frame_err !== 1'b1 || err_code !== 2'b01 || cyc !== h + 9) begin failures++; $display("FAIL len_err got=%b code=%b exp=1 code=01", frame_err, err_code); end
        checks++; if (frame_type !== 1'b1) begin failures++; $display("FAIL len_type got=%b exp=1", frame_type); end
        checks++; if (frame_busy !== 1'b0) begin failures++; $display("FAIL len_busy got=%b exp=0", frame_busy); end
        drive_byte(8'hFF, 8'h00, 8'h00);
        checks++; if (n_valid !== 0 || n_err !== 1 || n_done !== 0) begin failures++; $display("FAIL len_quiet got=v%0d e%0d d%0d exp=v0 e1 d0", n_valid, n_err, n_done); end
    endtask

    task automatic test_zero_len();
        clear_log();
        header(1'b0);
        drive_byte(8'h00, 8'h00, 8'h00);
        if (HAS_CS) drive_byte(8'h00, 8'h00, 8'h00);
        tick();
        checks++; if (n_done !== 1 || done_cyc !== h + 9 + CS || n_valid !== 0) begin failures++; $display("FAIL zero_done got=%0d@%0d v=%0d exp=1@%0d v=0", n_done, done_cyc - h, n_valid, 9 + CS); end
    endtask

    task automatic test_overflow();
        clear_log();
        byte_ready = 1'b0;
        header(1'b0);
        drive_byte(8'h03, 8'h00, 8'h00);
        drive_byte(8'h11, 8'h00, 8'h00);
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'h11 || byte_last !== 1'b0) begin failures++; $display("FAIL ovf_first got=%b/%h/%b exp=1/11/0", byte_valid, byte_data, byte_last); end
        for (int i = 7; i >= 1; i--) begin
            sequence_in = 1'(8'h22 >> i);
            tick();
        end
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'h11 || frame_err !== 1'b0) begin failures++; $display("FAIL ovf_hold got=%b/%h err=%b exp=1/11 err=0", byte_valid, byte_data, frame_err); end
        sequence_in = 1'b0;
        tick();
        checks++; if (frame_err !== 1'b1 || err_code !== 2'b11) begin failures++; $display("FAIL ovf_err got=%b code=%b exp=1 code=11", frame_err, err_code); end
        checks++; if (byte_valid !== 1'b0 || frame_busy !== 1'b0) begin failures++; $display("FAIL ovf_flush got=v%b b%b exp=v0 b0", byte_valid, frame_busy); end
        byte_ready = 1'b1;
        tick();
        checks++; if (rx_data.size() !== 0) begin failures++; $display("FAIL ovf_rx got=%0d exp=0", rx_data.size()); end
    endtask

    task automatic test_back_to_back();
        int h_a;
        clear_log();
        header(1'b0);
        h_a = h;
        drive_byte(8'h01, 8'h00, 8'h00);
        drive_byte(8'h5A, 8'h24, 8'h81);
        if (HAS_CS) drive_byte(8'h5B, 8'h00, 8'h00);
        checks++; if (frame_done !== 1'b1 || cyc !== h_a + 17 + CS) begin failures++; $display("FAIL b2b_first_done got=%b@%0d exp=1@%0d", frame_done, cyc - h_a, 17 + CS); end
        header(1'b1);
        drive_byte(8'h02, 8'h00, 8'h00);
        drive_byte(8'h0F, 8'h00, 8'h00);
        drive_byte(8'hF0, 8'h00, 8'h00);
        if (HAS_CS) drive_byte(8'hFD, 8'h00, 8'h00);
        tick();
        checks++; if (rx_data.size() !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", rx_data.size()); end
        if (rx_data.size() == 3) begin
            checks++; if (rx_data[0] !== 8'h5A || rx_last[0] !== 1'b1) begin failures++; $display("FAIL b2b_a0 got=%h/%b exp=5a/1", rx_data[0], rx_last[0]); end
            checks++; if (rx_data[1] !== 8'h0F || rx_data[2] !== 8'hF0 || rx_last[2] !== 1'b1) begin failures++; $display("FAIL b2b_b got=%h %h/%b exp=0f f0/1", rx_data[1], rx_data[2], rx_last[2]); end
        end
        checks++; if (n_done !== 2 || n_err !== 0 || done_cyc !== h + 25 + CS) begin failures++; $display("FAIL b2b_done got=d%0d e%0d @%0d exp=d2 e0 @%0d", n_done, n_err, done_cyc - h, 25 + CS); end
        checks++; if (frame_type !== 1'b1) begin failures++; $display("FAIL b2b_type got=%b exp=1", frame_type); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        byte_ready = 1'b0;
        header(1'b1);
        drive_byte(8'h02, 8'h00, 8'h00);
        drive_byte(8'hA5, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin sequence_in = 1'b1; tick(); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({byte_valid, byte_last, frame_type, frame_busy, frame_done, frame_err} !== 6'b0 || byte_data !== 8'h00 || err_code !== 2'b00) begin failures++; $display("FAIL rstmid_outputs got=%b data=%h code=%b exp=000000 data=00 code=00", {byte_valid, byte_last, frame_type, frame_busy, frame_done, frame_err}, byte_data, err_code); end
        checks++; if (n_err !== 0) begin failures++; $display("FAIL rstmid_no_err got=%0d exp=0", n_err); end
        byte_ready = 1'b1;
        clear_log();
        tick();
        header(1'b0);
        drive_byte(8'h01, 8'h00, 8'h00);
        drive_byte(8'h77, 8'h00, 8'h00);
        if (HAS_CS) drive_byte(8'h76, 8'h00, 8'h00);
        tick();
        checks++; if (rx_data.size() !== 1 || n_done !== 1 || n_err !== 0) begin failures++; $display("FAIL rstmid_next got=n%0d d%0d e%0d exp=n1 d1 e0", rx_data.size(), n_done, n_err); end
        if (rx_data.size() == 1) begin
            checks++; if (rx_data[0] !== 8'h77) begin failures++; $display("FAIL rstmid_byte got=%h exp=77", rx_data[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
`ifdef FRAME_CHECKSUM_EN
        test_bad_csum();
`endif
        test_len_err();
        test_zero_len();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
